// File: rtl/uart_rx_flow_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling default,
// frame width and the baud divider calculation. Also used by the TX side
// so that both directions derive identical bit timing.
package uart_rx_flow_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int FRAME_BITS     = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  // Clocks per oversample tick, truncated, never below 1.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int d;
    d = clk_hz / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO with occupancy count.
// Latency: a pushed word is visible on o_data/o_valid the cycle after the push.
// Backpressure: push on full is accepted only with a same-cycle pop; pop on empty is ignored.
// Ports: clk, rst (async, active-high); i_push/i_data write side; i_pop read side;
//        o_data/o_valid head word; o_full; o_count occupancy (0..DEPTH).
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full,
  output logic [AW:0]      o_count
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign w_do_pop  = i_pop & ~w_empty;
  // A pop frees the slot in the same edge, so a full FIFO can still take a push.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Head is forced to zero while empty so stale storage never leaks out.
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_valid = ~w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/uart_rx_flow.sv
// 8N1 UART receiver with oversampled start/stop validation, FWFT byte buffer and RTS.
// Latency: 2-cycle rx synchronizer; byte on m_data the cycle after the mid-stop-bit sample.
// Backpressure: m_valid/m_ready stream; rts=1 once buffer holds FIFO_DEPTH-1 bytes, overrun pulses on drop.
// Ports: clk, rst (async, active-high); rx serial in; rts active-low to host;
//        m_data/m_valid/m_ready byte stream; frame_err, overrun one-cycle pulses; rx_busy.
module uart_rx_flow import uart_rx_flow_pkg::*; #(
  parameter int CLK_FREQ_HZ = 200_000_000,
  parameter int BAUD        = 115200,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic                  rts,
  output logic [FRAME_BITS-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  rx_busy
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(FRAME_BITS);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] RTS_LEVEL = CW'(FIFO_DEPTH - 1);

  logic [1:0]            r_sync;
  logic [DW-1:0]         r_div_cnt;
  rx_state_t             r_state;
  rx_state_t             w_state_nxt;
  logic [SW-1:0]         r_samp;
  logic [SW-1:0]         w_samp_nxt;
  logic [BW-1:0]         r_bit;
  logic [BW-1:0]         w_bit_nxt;
  logic [FRAME_BITS-1:0] r_shift;
  logic [FRAME_BITS-1:0] w_shift_nxt;
  logic                  r_rts;
  logic                  w_rx;
  logic                  w_tick;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic [CW-1:0]         w_count;

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], rx};
  end
  assign w_rx = r_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_div_cnt <= '0;
    else if (w_tick) r_div_cnt <= '0;
    else             r_div_cnt <= r_div_cnt + 1'b1;
  end
  assign w_tick = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_samp  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_samp  <= w_samp_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // The sample counter is re-zeroed at mid-start, so every later wrap at
  // SAMP_LAST lands in the middle of a bit.
  always_comb begin
    w_state_nxt = r_state;
    w_samp_nxt  = r_samp;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    frame_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tick && !w_rx) begin
          w_state_nxt = ST_START;
          w_samp_nxt  = '0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_samp == SAMP_MID) begin
            w_samp_nxt = '0;
            w_bit_nxt  = '0;
            // A start bit that is gone by mid-bit was a glitch.
            w_state_nxt = w_rx ? ST_IDLE : ST_DATA;
          end else begin
            w_samp_nxt = r_samp + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_samp == SAMP_LAST) begin
            w_samp_nxt  = '0;
            w_shift_nxt = {w_rx, r_shift[FRAME_BITS-1:1]};
            if (r_bit == BIT_LAST) w_state_nxt = ST_STOP;
            else                   w_bit_nxt   = r_bit + 1'b1;
          end else begin
            w_samp_nxt = r_samp + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_samp == SAMP_LAST) begin
            w_samp_nxt = '0;
            // Leaving at mid-stop absorbs up to half a bit of baud mismatch.
            if (w_rx) begin
              w_push      = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              frame_err   = 1'b1;
              w_state_nxt = ST_BREAK;
            end
          end else begin
            w_samp_nxt = r_samp + 1'b1;
          end
        end
      end
      ST_BREAK: begin
        // Hold off until the line recovers so a break yields a single error.
        if (w_rx) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign rx_busy = (r_state != ST_IDLE);
  assign w_pop   = m_valid & m_ready;
  assign overrun = w_push & w_full & ~w_pop;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FRAME_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (w_pop),
    .o_data  (m_data),
    .o_valid (m_valid),
    .o_full  (w_full),
    .o_count (w_count)
  );

  // Raised one slot early so a byte already on the wire still fits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rts <= 1'b1;
    else     r_rts <= (w_count >= RTS_LEVEL);
  end
  assign rts = r_rts;

endmodule
